i2c_byte_seq: RTL and testbench

I2C_BYTE_SEQ -- requirements
Module: i2c_byte_seq

---
 rtl/i2c_byte_seq_if.sv | 29 ++
 rtl/i2c_byte_seq.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_byte_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_byte_seq_if.sv
// Command/response and open-drain line bundle for the I2C byte sequencer.
// The slave side is the sequencer; the master side issues commands and models the bus.
interface i2c_byte_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_nack;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_i;
    logic       sda_i;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_nack, scl_i, sda_i,
        output cmd_ready, rsp_valid, rsp_data, rsp_nack, busy,
        output scl_oe, sda_oe
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_nack, scl_i, sda_i,
        input  cmd_ready, rsp_valid, rsp_data, rsp_nack, busy,
        input  scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_byte_seq.sv
// I2C byte-level sequencer: START/WRITE/READ/STOP built from 4-quarter bit cells,
// with clock stretching and registered open-drain enables.
module i2c_byte_seq #(
    parameter int DIVIDER = 250,
    parameter int CBITS   = 10
) (
    input logic          clk,
    input logic          rst,
    i2c_byte_seq_if.slave io
);
    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    localparam logic [CBITS-1:0] ONE   = CBITS'(1);
    localparam logic [CBITS-1:0] Q1_AT = CBITS'(DIVIDER);
    localparam logic [CBITS-1:0] Q2_AT = CBITS'(2 * DIVIDER);
    localparam logic [CBITS-1:0] Q3_AT = CBITS'(3 * DIVIDER);
    localparam logic [CBITS-1:0] SMP   = CBITS'(3 * DIVIDER - 1);
    localparam logic [CBITS-1:0] LAST  = CBITS'(4 * DIVIDER - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, ACK, STOP, DONE} state_t;

    state_t           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [2:0]       bitn_q, bitn_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             rd_q, rd_d;
    logic             nack_q, nack_d;
    logic             rstart_q, rstart_d;
    logic             bus_q, bus_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_nack_q, rsp_nack_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;

    logic accept, adv, last, smp;

    assign io.cmd_ready = !busy_q && !rst;
    assign accept       = io.cmd_valid && !busy_q && !rst;
    // A released SCL still read low means a slave is stretching the clock.
    assign adv  = scl_q || io.scl_i;
    assign last = adv && (cnt_q == LAST);
    assign smp  = adv && (cnt_q == SMP);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitn_d      = bitn_q;
        shreg_d     = shreg_q;
        rd_d        = rd_q;
        nack_d      = nack_q;
        rstart_d    = rstart_q;
        bus_d       = bus_q;
        ack_d       = ack_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_nack_d  = rsp_nack_q;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    cnt_d  = '0;
                    bitn_d = '0;
                    unique case (io.cmd_op)
                        OP_START: begin
                            state_d  = START;
                            busy_d   = 1'b1;
                            rstart_d = bus_q;
                        end
                        OP_WRITE, OP_READ: begin
                            if (bus_q) begin
                                state_d = DATA;
                                busy_d  = 1'b1;
                                rd_d    = (io.cmd_op == OP_READ);
                                nack_d  = io.cmd_nack;
                                shreg_d = io.cmd_data;
                            end else begin
                                state_d     = DONE;
                                rsp_valid_d = 1'b1;
                                rsp_nack_d  = 1'b1;
                            end
                        end
                        OP_STOP: begin
                            if (bus_q) begin
                                state_d = STOP;
                                busy_d  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            START: begin
                if (adv) cnt_d = cnt_q + ONE;
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    bus_d   = 1'b1;
                end
            end
            DATA: begin
                if (adv) cnt_d = cnt_q + ONE;
                if (smp && rd_q) shreg_d = {shreg_q[6:0], io.sda_i};
                if (last) begin
                    cnt_d  = '0;
                    bitn_d = bitn_q + 3'd1;
                    if (!rd_q) shreg_d = {shreg_q[6:0], 1'b0};
                    if (bitn_q == 3'd7) state_d = ACK;
                end
            end
            ACK: begin
                if (adv) cnt_d = cnt_q + ONE;
                if (smp) ack_d = io.sda_i;
                if (last) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    busy_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_nack_d  = rd_q ? 1'b0 : ack_q;
                    if (rd_q) rsp_data_d = shreg_q;
                end
            end
            STOP: begin
                if (adv) cnt_d = cnt_q + ONE;
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    bus_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line enables are derived from the next state so they are registered.
        scl_d = 1'b0;
        sda_d = 1'b0;
        unique case (state_d)
            IDLE, DONE: begin
                scl_d = bus_d;
                sda_d = bus_d && sda_q;
            end
            START: begin
                scl_d = rstart_d && (cnt_d < Q1_AT);
                sda_d = (cnt_d >= Q2_AT);
            end
            DATA: begin
                scl_d = (cnt_d < Q2_AT);
                sda_d = !rd_d && !shreg_d[7];
            end
            ACK: begin
                scl_d = (cnt_d < Q2_AT);
                sda_d = rd_d && !nack_d;
            end
            STOP: begin
                scl_d = (cnt_d < Q2_AT);
                sda_d = (cnt_d < Q3_AT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitn_q      <= '0;
            shreg_q     <= '0;
            rd_q        <= 1'b0;
            nack_q      <= 1'b0;
            rstart_q    <= 1'b0;
            bus_q       <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_nack_q  <= 1'b0;
            rsp_data_q  <= 8'h00;
            scl_q       <= 1'b0;
            sda_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitn_q      <= bitn_d;
            shreg_q     <= shreg_d;
            rd_q        <= rd_d;
            nack_q      <= nack_d;
            rstart_q    <= rstart_d;
            bus_q       <= bus_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_nack_q  <= rsp_nack_d;
            rsp_data_q  <= rsp_data_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
        end
    end

    assign io.busy      = busy_q;
    assign io.rsp_valid = rsp_valid_q;
    assign io.rsp_nack  = rsp_nack_q;
    assign io.rsp_data  = rsp_data_q;
    assign io.scl_oe    = scl_q;
    assign io.sda_oe    = sda_q;
endmodule

// File: tb/tb_i2c_byte_seq.sv
// Bench for i2c_byte_seq: directed and random commands against a bus-level
// slave model that watches SCL edges and START/STOP conditions.
module tb_i2c_byte_seq;
    localparam int D = 4;
    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    logic slv_pull = 1'b0;
    int total = 0;
    int bad = 0;
    logic bus_m = 1'b0;
    logic [7:0] rsp_m = 8'h00;

    i2c_byte_seq_if io();

    assign io.scl_i = !(io.scl_oe || hold);
    assign io.sda_i = !(io.sda_oe || slv_pull);

    i2c_byte_seq #(.DIVIDER(D), .CBITS(4)) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                           input logic nk, input logic [7:0] sbyte,
                           input logic sack, input int slen_in);
        logic legal, is_data, pscl, psda, scl, sda, oe_seen, got_nack, bit9;
        int t, idx, slen, end_exp, rv_t, nrv, n_scl, starts, stops;
        logic [7:0] got_byte, got_rsp;
        logic bits[$];
        is_data = (op == OP_WRITE) || (op == OP_READ);
        legal = (op == OP_START) || bus_m;
        slen = (legal && is_data) ? slen_in : 0;
        if (!legal) end_exp = 1;
        else if (is_data) end_exp = 36 * D + 1 + slen;
        else end_exp = 4 * D + 1;
        @(negedge clk);
        io.cmd_valid = 1'b1;
        io.cmd_op = op;
        io.cmd_data = data;
        io.cmd_nack = nk;
        #1;
        check("cmd_ready", io.cmd_ready, 1);
        pscl = io.scl_i;
        psda = io.sda_i;
        idx = 0;
        slv_pull = 1'b0;
        rv_t = -1;
        nrv = 0;
        n_scl = 0;
        starts = 0;
        stops = 0;
        oe_seen = 1'b0;
        got_rsp = 8'h00;
        got_nack = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            io.cmd_valid = 1'b0;
            hold = (t >= 1 + 2 * D) && (t < 1 + 2 * D + slen);
            #1;
            scl = io.scl_i;
            if (pscl && !scl) idx++;
            if (op == OP_WRITE) slv_pull = (idx == 8) && sack;
            else if (op == OP_READ) slv_pull = (idx < 8) && !sbyte[7-idx];
            else slv_pull = 1'b0;
            #1;
            sda = io.sda_i;
            if (!pscl && scl) bits.push_back(sda);
            if (pscl && scl && psda && !sda) starts++;
            if (pscl && scl && !psda && sda) stops++;
            pscl = scl;
            psda = sda;
            if (io.scl_oe || io.sda_oe) oe_seen = 1'b1;
            if (io.busy && io.scl_oe) n_scl++;
            if (io.rsp_valid) begin
                nrv++;
                if (rv_t < 0) rv_t = t;
                got_rsp = io.rsp_data;
                got_nack = io.rsp_nack;
            end
        end while (io.busy && t < 2000);
        hold = 1'b0;
        slv_pull = 1'b0;
        check("busy_timeout", io.busy, 0);
        check("end_cycle", t, end_exp);
        got_byte = 8'h00;
        for (int i = 0; i < 8; i++)
            if (i < bits.size()) got_byte[7-i] = bits[i];
        bit9 = (bits.size() > 8) ? bits[8] : 1'bx;
        if (is_data) begin
            check("rsp_count", nrv, 1);
            check("rsp_cycle", rv_t, end_exp);
            if (!legal) begin
                check("ill_nack", got_nack, 1);
                check("ill_lines", oe_seen, 0);
            end else begin
                check("scl_low_cycles", n_scl, 18 * D);
                check("scl_rises", bits.size(), 9);
                check("no_cond", starts + stops, 0);
                if (op == OP_WRITE) begin
                    check("wr_bits", got_byte, data);
                    check("wr_nack", got_nack, !sack);
                end else begin
                    check("rd_data", got_rsp, sbyte);
                    check("rd_nack", got_nack, 0);
                    check("rd_ack_bit", bit9, nk);
                    rsp_m = sbyte;
                end
            end
        end else begin
            check("rsp_count", nrv, 0);
            if (op == OP_START) begin
                check("start_scl_low", n_scl, bus_m ? D : 0);
                check("start_cond", starts, 1);
                check("start_no_stop", stops, 0);
                check("start_scl_held", io.scl_oe, 1);
                check("start_sda_held", io.sda_oe, 1);
                bus_m = 1'b1;
            end else if (legal) begin
                check("stop_scl_low", n_scl, 2 * D);
                check("stop_cond", stops, 1);
                check("stop_no_start", starts, 0);
                check("stop_scl_rel", io.scl_oe, 0);
                check("stop_sda_rel", io.sda_oe, 0);
                bus_m = 1'b0;
            end else begin
                check("ill_stop_lines", oe_seen, 0);
            end
        end
        check("rsp_data_hold", io.rsp_data, rsp_m);
    endtask

    initial begin
        logic [1:0] op;
        int sl;
        io.cmd_valid = 1'b0;
        io.cmd_op = 2'b00;
        io.cmd_data = 8'h00;
        io.cmd_nack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", io.cmd_ready, 0);
        check("rst_scl", io.scl_oe, 0);
        check("rst_sda", io.sda_oe, 0);
        check("rst_busy", io.busy, 0);
        check("rst_rsp_valid", io.rsp_valid, 0);
        check("rst_rsp_nack", io.rsp_nack, 0);
        check("rst_rsp_data", io.rsp_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_ready", io.cmd_ready, 1);

        run_cmd(OP_WRITE, 8'h5A, 1'b0, 8'h00, 1'b1, 0);
        run_cmd(OP_READ, 8'h00, 1'b0, 8'hFF, 1'b1, 0);
        run_cmd(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b1, 0);
        run_cmd(OP_START, 8'h00, 1'b0, 8'h00, 1'b1, 0);
        run_cmd(OP_WRITE, 8'hA5, 1'b0, 8'h00, 1'b1, 0);
        run_cmd(OP_WRITE, 8'h3C, 1'b0, 8'h00, 1'b1, 10);
        run_cmd(OP_WRITE, 8'hFF, 1'b0, 8'h00, 1'b0, 0);
        run_cmd(OP_READ, 8'h00, 1'b1, 8'h3C, 1'b1, 0);
        run_cmd(OP_READ, 8'h00, 1'b0, 8'hC3, 1'b1, 0);
        run_cmd(OP_START, 8'h00, 1'b0, 8'h00, 1'b1, 0);
        run_cmd(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b1, 0);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            sl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
            run_cmd(op, 8'($urandom), 1'($urandom), 8'($urandom),
                    1'($urandom), sl);
        end

        if (!bus_m) run_cmd(OP_START, 8'h00, 1'b0, 8'h00, 1'b1, 0);
        @(negedge clk);
        io.cmd_valid = 1'b1;
        io.cmd_op = OP_WRITE;
        io.cmd_data = 8'h81;
        @(negedge clk);
        io.cmd_valid = 1'b0;
        repeat (3 * 4 * D) @(negedge clk);
        #1;
        check("mid_busy", io.busy, 1);
        check("mid_scl", io.scl_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_scl", io.scl_oe, 0);
        check("mid_rst_sda", io.sda_oe, 0);
        check("mid_rst_busy", io.busy, 0);
        check("mid_rst_ready", io.cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("mid_post_ready", io.cmd_ready, 1);
        check("mid_post_data", io.rsp_data, 8'h00);
        bus_m = 1'b0;
        rsp_m = 8'h00;
        run_cmd(OP_WRITE, 8'h42, 1'b0, 8'h00, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
